// File: rtl/net_strength_resolver_if.sv
// Bundle of driver inputs and resolved-net outputs for net_strength_resolver.
// The master side drives the drivers; the slave side is the resolver.
interface net_strength_resolver_if #(
  parameter int W     = 16,
  parameter int NDRV  = 2,
  parameter int CNT_W = 8
);
  logic                in_valid;
  logic [NDRV-1:0]     drv_en;
  logic [NDRV*W-1:0]   drv_val;
  logic [NDRV*3-1:0]   drv_str0;
  logic [NDRV*3-1:0]   drv_str1;
  logic                clr_cnt;
  logic                out_valid;
  logic [W-1:0]        out_val;
  logic [W-1:0]        out_x;
  logic [W-1:0]        out_z;
  logic                conflict;
  logic [CNT_W-1:0]    conflict_cnt;

  modport master (
    output in_valid, drv_en, drv_val, drv_str0, drv_str1, clr_cnt,
    input  out_valid, out_val, out_x, out_z, conflict, conflict_cnt
  );

  modport slave (
    input  in_valid, drv_en, drv_val, drv_str0, drv_str1, clr_cnt,
    output out_valid, out_val, out_x, out_z, conflict, conflict_cnt
  );
endinterface

// File: rtl/net_strength_resolver.sv
// Multi-driver net resolver: per-bit strongest drive wins, equal-strength opposites give X,
// undriven bits go Z or (trireg) hold charge with optional decay. One registered output stage.
module net_strength_resolver #(
  parameter int W      = 16,
  parameter int NDRV   = 2,
  parameter int TRIREG = 0,
  parameter int DECAY  = 0,
  parameter int CNT_W  = 8
) (
  input  logic clk,
  input  logic rst,
  net_strength_resolver_if.slave bus
);
  localparam int AGE_W = (DECAY > 0) ? $clog2(DECAY + 1) : 1;
  localparam logic [AGE_W-1:0] AGE_LIM = (DECAY > 0) ? AGE_W'(DECAY) : '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  function automatic logic [AGE_W-1:0] sat_inc_age(input logic [AGE_W-1:0] a);
    return (a == AGE_LIM) ? a : a + 1'b1;
  endfunction

  logic [W-1:0]     res_one, res_zero;
  logic [W-1:0]     res_drv, res_cont, res_val;
  logic [2:0]       smax, s;
  logic             v;

  // Strength resolution (combinational, from driver inputs)
  always_comb begin
    res_one  = '0;
    res_zero = '0;
    smax     = '0;
    s        = '0;
    v        = 1'b0;
    for (int b = 0; b < W; b++) begin
      smax = '0;
      for (int i = 0; i < NDRV; i++) begin
        v = bus.drv_val[i*W + b];
        s = v ? bus.drv_str1[i*3 +: 3] : bus.drv_str0[i*3 +: 3];
        if (bus.drv_en[i] && (s > smax)) smax = s;
      end
      for (int i = 0; i < NDRV; i++) begin
        v = bus.drv_val[i*W + b];
        s = v ? bus.drv_str1[i*3 +: 3] : bus.drv_str0[i*3 +: 3];
        if (bus.drv_en[i] && (s != 3'd0) && (s == smax)) begin
          if (v) res_one[b]  = 1'b1;
          else   res_zero[b] = 1'b1;
        end
      end
    end
  end

  assign res_drv  = res_one | res_zero;
  assign res_cont = res_one & res_zero;
  assign res_val  = res_one & ~res_zero;

  logic             vld_p1, conflict_p1;
  logic [W-1:0]     val_p1, x_p1, z_p1, held_p1;
  logic [AGE_W-1:0] age_p1 [W];
  logic [CNT_W-1:0] cnt_p1;

  logic [W-1:0]     val_n, x_n, z_n, held_n;
  logic [AGE_W-1:0] age_n [W];
  logic             enter;
  logic             has_cont;

  assign has_cont = bus.in_valid && (|res_cont);

  // Next output/hold state per bit, including trireg charge decay
  always_comb begin
    val_n  = val_p1;
    x_n    = x_p1;
    z_n    = z_p1;
    held_n = held_p1;
    enter  = 1'b0;
    for (int b = 0; b < W; b++) age_n[b] = age_p1[b];
    for (int b = 0; b < W; b++) begin
      enter = 1'b0;
      if (bus.in_valid && res_drv[b]) begin
        val_n[b]  = res_val[b];
        x_n[b]    = res_cont[b];
        z_n[b]    = 1'b0;
        held_n[b] = 1'b0;
        age_n[b]  = '0;
      end else if (TRIREG == 0) begin
        if (bus.in_valid) begin
          val_n[b] = 1'b0;
          x_n[b]   = 1'b0;
          z_n[b]   = 1'b1;
        end
      end else begin
        // A bit that has never been driven since reset keeps reading Z.
        enter = bus.in_valid && !held_p1[b] && !z_p1[b];
        if (enter) begin
          held_n[b] = 1'b1;
          age_n[b]  = AGE_W'(1);
        end else if (held_p1[b]) begin
          age_n[b] = sat_inc_age(age_p1[b]);
        end
        if ((DECAY > 0) && held_n[b] && (age_n[b] == AGE_LIM)) begin
          val_n[b] = 1'b0;
          x_n[b]   = 1'b1;
        end
      end
    end
  end

  // Stage p1: registered outputs and conflict statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      val_p1      <= '0;
      x_p1        <= '0;
      z_p1        <= '1;
      held_p1     <= '0;
      conflict_p1 <= 1'b0;
      cnt_p1      <= '0;
      for (int b = 0; b < W; b++) age_p1[b] <= '0;
    end else begin
      vld_p1      <= bus.in_valid;
      val_p1      <= val_n;
      x_p1        <= x_n;
      z_p1        <= z_n;
      held_p1     <= held_n;
      conflict_p1 <= has_cont;
      for (int b = 0; b < W; b++) age_p1[b] <= age_n[b];
      if (bus.clr_cnt) cnt_p1 <= has_cont ? CNT_W'(1) : '0;
      else if (has_cont) cnt_p1 <= sat_inc_cnt(cnt_p1);
    end
  end

  assign bus.out_valid    = vld_p1;
  assign bus.out_val      = val_p1;
  assign bus.out_x        = x_p1;
  assign bus.out_z        = z_p1;
  assign bus.conflict     = conflict_p1;
  assign bus.conflict_cnt = cnt_p1;
endmodule

// File: tb/tb_net_strength_resolver.sv
// Bench for net_strength_resolver: a Z-mode instance (CNT_W=2) checked through a scoreboard and
// a trireg instance (DECAY=4) checked directly around hold, decay, counter and reset events.
module tb_net_strength_resolver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic [1:0]  drv_en   = '0;
  logic [31:0] drv_val  = '0;
  logic [5:0]  drv_str0 = '0;
  logic [5:0]  drv_str1 = '0;
  logic        clr_cnt  = 1'b0;

  net_strength_resolver_if #(.W(16), .NDRV(2), .CNT_W(2)) bus_z ();
  net_strength_resolver_if #(.W(16), .NDRV(2), .CNT_W(8)) bus_t ();

  assign bus_z.in_valid = in_valid;
  assign bus_z.drv_en   = drv_en;
  assign bus_z.drv_val  = drv_val;
  assign bus_z.drv_str0 = drv_str0;
  assign bus_z.drv_str1 = drv_str1;
  assign bus_z.clr_cnt  = clr_cnt;
  assign bus_t.in_valid = in_valid;
  assign bus_t.drv_en   = drv_en;
  assign bus_t.drv_val  = drv_val;
  assign bus_t.drv_str0 = drv_str0;
  assign bus_t.drv_str1 = drv_str1;
  assign bus_t.clr_cnt  = clr_cnt;

  net_strength_resolver #(.W(16), .NDRV(2), .TRIREG(0), .DECAY(0), .CNT_W(2)) dut_z (
    .clk(clk), .rst(rst), .bus(bus_z)
  );
  net_strength_resolver #(.W(16), .NDRV(2), .TRIREG(1), .DECAY(4), .CNT_W(8)) dut_t (
    .clk(clk), .rst(rst), .bus(bus_t)
  );

  typedef struct {
    logic [15:0] val;
    logic [15:0] x;
    logic [15:0] z;
    logic        conf;
    logic [1:0]  cnt;
  } exp_t;

  exp_t       sbq[$];
  int         n_chk = 0;
  int         n_err = 0;
  logic [1:0] cnt_z = '0;
  logic [7:0] cnt_t = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference: single pass per bit, tracking the strongest level and which values reach it.
  task automatic resolve(input logic [1:0] en, input logic [31:0] val,
                         input logic [5:0] s0, input logic [5:0] s1,
                         output logic [15:0] ov, output logic [15:0] ox, output logic [15:0] oz);
    logic [2:0] best, st;
    logic       saw0, saw1, bv;
    for (int b = 0; b < 16; b++) begin
      best = 3'd0; saw0 = 1'b0; saw1 = 1'b0;
      for (int i = 0; i < 2; i++) begin
        bv = val[i*16 + b];
        st = bv ? s1[i*3 +: 3] : s0[i*3 +: 3];
        if (en[i] && st != 3'd0) begin
          if (st > best) begin
            best = st; saw0 = !bv; saw1 = bv;
          end else if (st == best) begin
            saw0 = saw0 | !bv; saw1 = saw1 | bv;
          end
        end
      end
      oz[b] = !(saw0 || saw1);
      ox[b] = saw0 && saw1;
      ov[b] = saw1 && !saw0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] en, input logic [31:0] val, input logic [5:0] s0,
                       input logic [5:0] s1, input logic clr, input logic r);
    exp_t e;
    logic [15:0] ov, ox, oz;
    in_valid = 1'b1; drv_en = en; drv_val = val; drv_str0 = s0; drv_str1 = s1;
    clr_cnt = clr; rst = r;
    if (r) begin
      sbq.delete();
      cnt_z = '0;
      cnt_t = '0;
    end else begin
      resolve(en, val, s0, s1, ov, ox, oz);
      e.val = ov; e.x = ox; e.z = oz; e.conf = |ox;
      if (clr) begin
        cnt_z = e.conf ? 2'd1 : 2'd0;
        cnt_t = e.conf ? 8'd1 : 8'd0;
      end else if (e.conf) begin
        if (cnt_z != 2'd3) cnt_z = cnt_z + 2'd1;
        if (cnt_t != 8'hFF) cnt_t = cnt_t + 8'd1;
      end
      e.cnt = cnt_z;
      sbq.push_back(e);
    end
    step();
    in_valid = 1'b0; clr_cnt = 1'b0; rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus_z.out_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_out", 32'(bus_z.out_valid), 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("sb_val",  32'(bus_z.out_val), 32'(e.val));
        chk("sb_x",    32'(bus_z.out_x),   32'(e.x));
        chk("sb_z",    32'(bus_z.out_z),   32'(e.z));
        chk("sb_conf", 32'(bus_z.conflict), 32'(e.conf));
        chk("sb_cnt",  32'(bus_z.conflict_cnt), 32'(e.cnt));
      end
    end else if (!rst) begin
      chk("idle_conf", 32'(bus_z.conflict), 32'd0);
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_vld_z"}, 32'(bus_z.out_valid), 32'd0);
    chk({tag, "_val_z"}, 32'(bus_z.out_val), 32'd0);
    chk({tag, "_x_z"},   32'(bus_z.out_x), 32'd0);
    chk({tag, "_z_z"},   32'(bus_z.out_z), 32'hFFFF);
    chk({tag, "_cf_z"},  32'(bus_z.conflict), 32'd0);
    chk({tag, "_cnt_z"}, 32'(bus_z.conflict_cnt), 32'd0);
    chk({tag, "_vld_t"}, 32'(bus_t.out_valid), 32'd0);
    chk({tag, "_x_t"},   32'(bus_t.out_x), 32'd0);
    chk({tag, "_z_t"},   32'(bus_t.out_z), 32'hFFFF);
    chk({tag, "_cnt_t"}, 32'(bus_t.conflict_cnt), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk_reset("rst");

    // weak driver 0 loses to strong driver 1
    drive(2'b11, {16'hFFFF, 16'h0000}, {3'd6, 3'd3}, {3'd6, 3'd3}, 1'b0, 1'b0);
    // strong vs strong contention
    drive(2'b11, {16'h0F0F, 16'h00FF}, {3'd6, 3'd6}, {3'd6, 3'd6}, 1'b0, 1'b0);
    chk("t2_cnt_t", 32'(bus_t.conflict_cnt), 32'd1);
    chk("t2_x_t",   32'(bus_t.out_x), 32'h0FF0);
    // asymmetric strengths: weak tie on 4-7, strong tie on 8-11
    drive(2'b11, {16'h0F0F, 16'h00FF}, {3'd3, 3'd6}, {3'd6, 3'd3}, 1'b0, 1'b0);

    // trireg hold and decay
    drive(2'b01, {16'h0000, 16'hA5A5}, {3'd0, 3'd6}, {3'd0, 3'd6}, 1'b0, 1'b0);
    drive(2'b00, 32'h0, 6'd0, 6'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("hold_val_k%0d", k), 32'(bus_t.out_val), 32'hA5A5);
      chk($sformatf("hold_x_k%0d", k),   32'(bus_t.out_x), 32'h0000);
      chk($sformatf("hold_z_k%0d", k),   32'(bus_t.out_z), 32'h0000);
      step();
    end
    for (int k = 3; k < 5; k++) begin
      chk($sformatf("decay_x_k%0d", k),   32'(bus_t.out_x), 32'hFFFF);
      chk($sformatf("decay_val_k%0d", k), 32'(bus_t.out_val), 32'h0000);
      chk($sformatf("decay_z_k%0d", k),   32'(bus_t.out_z), 32'h0000);
      step();
    end
    drive(2'b10, {16'h1234, 16'h0000}, {3'd5, 3'd0}, {3'd5, 3'd0}, 1'b0, 1'b0);
    chk("redrive_val_t", 32'(bus_t.out_val), 32'h1234);
    chk("redrive_x_t",   32'(bus_t.out_x), 32'h0000);

    for (int n = 0; n < 24; n++) begin
      drive(2'($urandom_range(0, 3)), $urandom(), 6'($urandom()), 6'($urandom()),
            1'b0, 1'b0);
    end

    // saturating counter and clear
    drive(2'b00, 32'h0, 6'd0, 6'd0, 1'b1, 1'b0);
    chk("clr_alone_t", 32'(bus_t.conflict_cnt), 32'd0);
    for (int n = 0; n < 5; n++)
      drive(2'b11, {16'h0F0F, 16'h00FF}, {3'd6, 3'd6}, {3'd6, 3'd6}, 1'b0, 1'b0);
    chk("sat5_t", 32'(bus_t.conflict_cnt), 32'd5);
    drive(2'b11, {16'h0F0F, 16'h00FF}, {3'd6, 3'd6}, {3'd6, 3'd6}, 1'b1, 1'b0);
    chk("clr_cont_t", 32'(bus_t.conflict_cnt), 32'd1);

    // reset mid-stream with a contention sample presented
    drive(2'b01, {16'h0000, 16'hA5A5}, {3'd0, 3'd6}, {3'd0, 3'd6}, 1'b0, 1'b0);
    drive(2'b11, {16'h0F0F, 16'h00FF}, {3'd6, 3'd6}, {3'd6, 3'd6}, 1'b1, 1'b1);
    chk_reset("midrst");
    drive(2'b00, 32'h0, 6'd0, 6'd0, 1'b0, 1'b0);
    chk("post_rst_z_t", 32'(bus_t.out_z), 32'hFFFF);
    chk("post_rst_x_t", 32'(bus_t.out_x), 32'h0000);

    step();
    step();
    chk("final_cnt_t", 32'(bus_t.conflict_cnt), 32'(cnt_t));
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
